// File: rtl/frame_arb.sv
// frame_arb: two-requester frame arbiter with one-entry holding buffers.
// A new frame overwrites a full buffer, and the overwrite is reported on
// dropNIncr. One granted frame is offered downstream until it is accepted.
// Build option: define FRAME_ARB_RR_EN for round-robin arbitration. If it
// is not defined, requester 0 has fixed priority.
module frame_arb #(
    parameter int DW = 256
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enable,
    input  logic          req0Valid,
    input  logic [DW-1:0] req0Pdata,
    input  logic          req1Valid,
    input  logic [DW-1:0] req1Pdata,
    output logic          outValid,
    output logic [DW-1:0] outPdata,
    output logic          outSrc,
    input  logic          outAck,
    output logic          drop0Incr,
    output logic          drop1Incr,
    output logic          busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] buf0_q, buf0_d;
    logic [DW-1:0] buf1_q, buf1_d;
    logic          full0_q, full0_d;
    logic          full1_q, full1_d;
    logic [DW-1:0] out_pdata_q, out_pdata_d;
    logic          out_src_q, out_src_d;
    logic          drop0_q, drop0_d;
    logic          drop1_q, drop1_d;
    logic          grant0, grant1;
    logic          win0;

`ifdef FRAME_ARB_RR_EN
    logic          last_q, last_d;

    // When both buffers are full, the requester that was not granted last wins.
    always_comb win0 = last_q;
`else
    // Fixed priority: requester 0 wins every tie.
    always_comb win0 = 1'b1;
`endif

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments only. Each flop
    // then samples the value from before the edge, no matter which block runs first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: grant in IDLE, wait for acceptance in ISSUE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant0 || grant1) state_d = ISSUE;
            ISSUE:   if (outAck)           state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: pick the buffer to grant. Grants happen only while idle and enabled.
    // NOTE: every signal written here gets a default value first, so no latch is inferred.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && enable) begin
            if (full0_q && (!full1_q || win0)) grant0 = 1'b1;
            else if (full1_q)                  grant1 = 1'b1;
        end
    end

    // Output register: copy the granted buffer and remember who granted last.
    always_comb begin
        out_pdata_d = out_pdata_q;
        out_src_d   = out_src_q;
        if (grant0) begin
            out_pdata_d = buf0_q;
            out_src_d   = 1'b0;
        end else if (grant1) begin
            out_pdata_d = buf1_q;
            out_src_d   = 1'b1;
        end
    end

`ifdef FRAME_ARB_RR_EN
    // Last-grant pointer update.
    always_comb begin
        last_d = last_q;
        if (grant0)      last_d = 1'b0;
        else if (grant1) last_d = 1'b1;
    end
`endif

    // Holding buffers. Newest frame wins. A frame lost to an overwrite is counted,
    // unless the old frame is granted on the same edge.
    always_comb begin
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        full0_d = full0_q;
        full1_d = full1_q;
        drop0_d = 1'b0;
        drop1_d = 1'b0;
        if (!enable) begin
            full0_d = 1'b0;
            full1_d = 1'b0;
        end else begin
            if (req0Valid) begin
                buf0_d  = req0Pdata;
                full0_d = 1'b1;
                drop0_d = full0_q && !grant0;
            end else if (grant0) begin
                full0_d = 1'b0;
            end
            if (req1Valid) begin
                buf1_d  = req1Pdata;
                full1_d = 1'b1;
                drop1_d = full1_q && !grant1;
            end else if (grant1) begin
                full1_d = 1'b0;
            end
        end
    end

    // Control and output flops, with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full0_q     <= 1'b0;
            full1_q     <= 1'b0;
            out_pdata_q <= '0;
            out_src_q   <= 1'b0;
            drop0_q     <= 1'b0;
            drop1_q     <= 1'b0;
`ifdef FRAME_ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            full0_q     <= full0_d;
            full1_q     <= full1_d;
            out_pdata_q <= out_pdata_d;
            out_src_q   <= out_src_d;
            drop0_q     <= drop0_d;
            drop1_q     <= drop1_d;
`ifdef FRAME_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    // Buffer data storage.
    // NOTE: buffer data has no reset. The full flags qualify it, so stale
    // contents after reset are never observed.
    always_ff @(posedge clk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

    assign outValid  = (state_q == ISSUE);
    assign outPdata  = out_pdata_q;
    assign outSrc    = out_src_q;
    assign drop0Incr = drop0_q;
    assign drop1Incr = drop1_q;
    assign busy      = full0_q || full1_q || (state_q == ISSUE);

endmodule
